led_serial_rx: RTL and testbench
================================

// Module: led_serial_rx
// PURPOSE
//  Bit-serial receiver for the LED blink link: samples one serial line (LED drive or photodiode),
//  reassembles WORD_W-bit words sent LSB first at a fixed bit period, flags framing errors.
//  Sits at the far end of the LED transmitter; recovered words feed the uncertainty datapath
//  (e.g. negate16bit result checking) on the 10 kHz SB_LFOSC clock domain.
// PARAMETERS
//  BIT_PERIOD  1252  clk cycles per serial bit (matches the transmitter's count>1250 reload)
//  WORD_W      32    data bits per frame
//  CNT_W       11    bit-period counter width; must satisfy 2^CNT_W > BIT_PERIOD
// PORTS
//  clk         in   1       system clock (SB_LFOSC CLKLF, 10 kHz)
//  rst_n       in   1       asynchronous active-low reset
//  rx_in       in   1       serial line, asynchronous to clk; idle level 0
//  word        out  WORD_W  last received word; holds until next good frame
//  word_valid  out  1       1-cycle pulse when word updates
//  frame_err   out  1       1-cycle pulse: stop bit sampled 1
//  parity_err  out  1       1-cycle pulse: parity mismatch (tied 0 without PARITY_CHECK_EN)
//  busy        out  1       1 while not in IDLE
// BEHAVIOUR
//  - Frame: start bit 1, WORD_W data bits LSB first, [parity bit], stop bit 0. One bit = BIT_PERIOD clk.
//  - rx_in passes a 2-flop synchronizer (rx_s); 2-cycle input latency, included in all timing below.
//  - Reset (rst_n=0, any time incl. mid-frame): state=IDLE, counters=0, word=0, all pulses=0, busy=0.
//  - FSM:
//    IDLE:   rx_s==1 -> START, cnt=0.
//    START:  at cnt==BIT_PERIOD/2-1 sample: rx_s==1 -> DATA, cnt=0, bitidx=0; rx_s==0 -> IDLE (glitch, no flag).
//    DATA:   at cnt==BIT_PERIOD-1 shift rx_s into shreg[bitidx], cnt=0; after bit WORD_W-1 -> PARITY or STOP.
//    PARITY: (macro only) at cnt==BIT_PERIOD-1 capture parity bit -> STOP.
//    STOP:   at cnt==BIT_PERIOD-1 sample; rx_s==0 and parity ok -> word<=shreg, word_valid=1;
//            rx_s==1 -> frame_err=1, word unchanged; parity bad -> parity_err=1, word unchanged.
//            Both may assert together. Then -> IDLE.
//  - Samples land mid-bit: first data sample 1.5*BIT_PERIOD after start edge (+2 sync cycles).
//  - word_valid/frame_err/parity_err are registered, high exactly one cycle, default 0.
//  - Back-to-back frames: a start bit right after the stop bit is accepted; IDLE needs 1 cycle min.
//  - Frame with stop bit stuck at 1: after error, IDLE immediately sees rx_s==1 and re-enters
//    START; resync is by design, no lockout.
//  - bitidx counts 0..WORD_W-1, never wraps mid-frame; cnt never exceeds BIT_PERIOD-1.
// CONFIGURATION
//  PARITY_CHECK_EN defined: frame carries an even-parity bit (XOR of data^parity == 0) between
//   data and stop; PARITY state active; mismatch -> parity_err pulse, word not updated.
//  PARITY_CHECK_EN undefined: no PARITY state, frame = 1+WORD_W+1 bits, parity_err tied 0.
// TESTING  (bench uses BIT_PERIOD=8, WORD_W=32)
//  1 frame 0xCB2BEACF, stop 0 -> word=0xCB2BEACF, word_valid 1 cycle, frame_err=0, busy low after.
//  2 frame 0x34D51531 directly after frame 1 (no idle gap) -> two word_valid pulses, words in order.
//  3 rx_in high 2 cycles then low (glitch < BIT_PERIOD/2) -> back to IDLE, no pulses, word unchanged.
//  4 frame 0x0000FFFF with stop bit 1 -> frame_err 1 cycle, word_valid 0, word holds prior value.
//  5 rst_n low for 1 cycle at data bit 10 of a frame -> all outputs 0, next full frame 0xA5A5A5A5 ok.
//  6 PARITY_CHECK_EN: 0x00000001 with parity 1 -> valid; with parity 0 -> parity_err, word unchanged.

Source files
------------

// File: rtl/led_serial_rx.sv
// Bit-serial receiver for the LED blink link: 2-flop synchronizer, start/data/stop framing, LSB first.
// Define PARITY_CHECK_EN to expect an even-parity bit between the data and stop bits.
module led_serial_rx #(
  parameter int unsigned BIT_PERIOD = 1252,
  parameter int unsigned WORD_W     = 32,
  parameter int unsigned CNT_W      = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_in,
  output logic [WORD_W-1:0] word,
  output logic              word_valid,
  output logic              frame_err,
  output logic              parity_err,
  output logic              busy
);

  localparam int unsigned IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_PERIOD / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(BIT_PERIOD - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(WORD_W - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e             state;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   bitidx;
  logic [WORD_W-1:0]  shreg;
  logic               rx_meta;
  logic               rx_s;
  logic               par_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b0;
      rx_s    <= 1'b0;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
    end
  end

`ifdef PARITY_CHECK_EN
  logic par_bit;
  logic par_err_q;

  // Even parity: data bits and the parity bit XOR to zero.
  assign par_ok     = ~(^shreg ^ par_bit);
  assign parity_err = par_err_q;
`else
  assign par_ok     = 1'b1;
  assign parity_err = 1'b0;
`endif

  assign busy = (state != StIdle);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= StIdle;
      cnt        <= '0;
      bitidx     <= '0;
      shreg      <= '0;
      word       <= '0;
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
`ifdef PARITY_CHECK_EN
      par_bit    <= 1'b0;
      par_err_q  <= 1'b0;
`endif
    end else begin
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
`ifdef PARITY_CHECK_EN
      par_err_q  <= 1'b0;
`endif
      unique case (state)
        StIdle: begin
          if (rx_s) begin
            state <= StStart;
            cnt   <= '0;
          end
        end
        StStart: begin
          // Half-period check rejects glitches and aligns later samples to mid-bit.
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              state  <= StData;
              bitidx <= '0;
            end else begin
              state <= StIdle;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StData: begin
          if (cnt == FULL_LAST) begin
            cnt           <= '0;
            shreg[bitidx] <= rx_s;
            if (bitidx == IDX_LAST) begin
`ifdef PARITY_CHECK_EN
              state <= StParity;
`else
              state <= StStop;
`endif
            end else begin
              bitidx <= bitidx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef PARITY_CHECK_EN
        StParity: begin
          if (cnt == FULL_LAST) begin
            cnt     <= '0;
            par_bit <= rx_s;
            state   <= StStop;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        StStop: begin
          if (cnt == FULL_LAST) begin
            cnt   <= '0;
            state <= StIdle;
            if (rx_s) begin
              frame_err <= 1'b1;
            end
`ifdef PARITY_CHECK_EN
            if (!par_ok) begin
              par_err_q <= 1'b1;
            end
`endif
            if (!rx_s && par_ok) begin
              word       <= shreg;
              word_valid <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_led_serial_rx.sv
// Self-checking bench for led_serial_rx: directed frames plus randomized frames vs a frame-level model.
module tb_led_serial_rx;

  localparam int unsigned BP     = 8;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = 4;
`ifdef PARITY_CHECK_EN
  localparam int unsigned PAR = 1;
`else
  localparam int unsigned PAR = 0;
`endif
  // Cycles from driving the start bit to seeing the result pulse (sync + half bit + remaining bits).
  localparam int LAT = 3 + BP / 2 + (WORD_W + 1 + PAR) * BP;

  logic              clk;
  logic              rst_n;
  logic              rx_in;
  logic [WORD_W-1:0] word;
  logic              word_valid;
  logic              frame_err;
  logic              parity_err;
  logic              busy;

  int checks;
  int failures;
  int cyc;

  int                got_wv_cyc[$];
  logic [WORD_W-1:0] got_wv_word[$];
  int                got_fe_cyc[$];
  int                got_pe_cyc[$];

  led_serial_rx #(
    .BIT_PERIOD (BP),
    .WORD_W     (WORD_W),
    .CNT_W      (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_in      (rx_in),
    .word       (word),
    .word_valid (word_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (word_valid) begin
      got_wv_cyc.push_back(cyc);
      got_wv_word.push_back(word);
    end
    if (frame_err) got_fe_cyc.push_back(cyc);
    if (parity_err) got_pe_cyc.push_back(cyc);
  end

  task automatic clear_got();
    got_wv_cyc.delete();
    got_wv_word.delete();
    got_fe_cyc.delete();
    got_pe_cyc.delete();
  endtask

  task automatic drive_bit(input logic b, input int n);
    rx_in = b;
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; returns the cycle stamp when the start bit was driven.
  task automatic send_frame(input logic [WORD_W-1:0] data, input logic stop, input logic flip,
                            input int gap, output int start);
    start = cyc;
    drive_bit(1'b1, BP);
    for (int i = 0; i < int'(WORD_W); i++) drive_bit(data[i], BP);
    if (PAR != 0) drive_bit((^data) ^ flip, BP);
    drive_bit(stop, BP);
    rx_in = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx_in = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (word !== '0 || word_valid !== 1'b0 || frame_err !== 1'b0 || parity_err !== 1'b0 ||
        busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: word=%h wv=%b fe=%b pe=%b busy=%b, required all 0",
               word, word_valid, frame_err, parity_err, busy);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    int s;
    clear_got();
    send_frame(32'hCB2BEACF, 1'b0, 1'b0, 4, s);
    checks++;
    if (got_wv_cyc.size() != 1) begin
      failures++;
      $display("FAIL single_wv_count: got %0d pulses, required 1", got_wv_cyc.size());
    end else begin
      checks++;
      if (got_wv_word[0] !== 32'hCB2BEACF) begin
        failures++;
        $display("FAIL single_word: got %h, required cb2beacf", got_wv_word[0]);
      end
      checks++;
      if (got_wv_cyc[0] != s + LAT) begin
        failures++;
        $display("FAIL single_latency: got cycle %0d, required %0d", got_wv_cyc[0], s + LAT);
      end
    end
    checks++;
    if (got_fe_cyc.size() != 0 || got_pe_cyc.size() != 0) begin
      failures++;
      $display("FAIL single_errs: fe=%0d pe=%0d pulses, required 0", got_fe_cyc.size(),
               got_pe_cyc.size());
    end
    checks++;
    if (busy !== 1'b0 || word !== 32'hCB2BEACF) begin
      failures++;
      $display("FAIL single_after: busy=%b word=%h, required busy=0 word=cb2beacf", busy, word);
    end
  endtask

  task automatic test_back_to_back();
    int s1, s2;
    clear_got();
    send_frame(32'hCB2BEACF, 1'b0, 1'b0, 0, s1);
    send_frame(32'h34D51531, 1'b0, 1'b0, 4, s2);
    checks++;
    if (got_wv_cyc.size() != 2) begin
      failures++;
      $display("FAIL b2b_count: got %0d pulses, required 2", got_wv_cyc.size());
    end else begin
      checks++;
      if (got_wv_word[0] !== 32'hCB2BEACF || got_wv_word[1] !== 32'h34D51531) begin
        failures++;
        $display("FAIL b2b_words: got %h,%h, required cb2beacf,34d51531", got_wv_word[0],
                 got_wv_word[1]);
      end
      checks++;
      if (got_wv_cyc[0] != s1 + LAT || got_wv_cyc[1] != s2 + LAT) begin
        failures++;
        $display("FAIL b2b_timing: got %0d,%0d, required %0d,%0d", got_wv_cyc[0], got_wv_cyc[1],
                 s1 + LAT, s2 + LAT);
      end
    end
  endtask

  task automatic test_glitch();
    clear_got();
    drive_bit(1'b1, 2);
    drive_bit(1'b0, 3 * BP);
    checks++;
    if (got_wv_cyc.size() != 0 || got_fe_cyc.size() != 0 || got_pe_cyc.size() != 0) begin
      failures++;
      $display("FAIL glitch_pulses: wv=%0d fe=%0d pe=%0d, required 0", got_wv_cyc.size(),
               got_fe_cyc.size(), got_pe_cyc.size());
    end
    checks++;
    if (word !== 32'h34D51531 || busy !== 1'b0) begin
      failures++;
      $display("FAIL glitch_state: word=%h busy=%b, required 34d51531 0", word, busy);
    end
  endtask

  task automatic test_frame_err();
    int s;
    clear_got();
    send_frame(32'h0000FFFF, 1'b1, 1'b0, 3 * BP, s);
    checks++;
    if (got_fe_cyc.size() != 1) begin
      failures++;
      $display("FAIL ferr_count: got %0d pulses, required 1", got_fe_cyc.size());
    end else begin
      checks++;
      if (got_fe_cyc[0] != s + LAT) begin
        failures++;
        $display("FAIL ferr_timing: got %0d, required %0d", got_fe_cyc[0], s + LAT);
      end
    end
    checks++;
    if (got_wv_cyc.size() != 0 || word !== 32'h34D51531 || busy !== 1'b0) begin
      failures++;
      $display("FAIL ferr_hold: wv=%0d word=%h busy=%b, required 0 34d51531 0",
               got_wv_cyc.size(), word, busy);
    end
  endtask

  task automatic test_reset_mid();
    int s;
    logic [WORD_W-1:0] d;
    d = 32'h5A3C_96E1;
    drive_bit(1'b1, BP);
    for (int i = 0; i < 10; i++) drive_bit(d[i], BP);
    drive_bit(d[10], 3);
    rst_n = 1'b0;
    #1;
    checks++;
    if (word !== '0 || word_valid !== 1'b0 || frame_err !== 1'b0 || parity_err !== 1'b0 ||
        busy !== 1'b0) begin
      failures++;
      $display("FAIL midreset_state: word=%h wv=%b fe=%b pe=%b busy=%b, required all 0",
               word, word_valid, frame_err, parity_err, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive_bit(1'b0, 2 * BP);
    clear_got();
    send_frame(32'hA5A5A5A5, 1'b0, 1'b0, 4, s);
    checks++;
    if (got_wv_cyc.size() != 1 || got_fe_cyc.size() != 0) begin
      failures++;
      $display("FAIL midreset_count: wv=%0d fe=%0d, required 1 0", got_wv_cyc.size(),
               got_fe_cyc.size());
    end else begin
      checks++;
      if (got_wv_word[0] !== 32'hA5A5A5A5 || got_wv_cyc[0] != s + LAT) begin
        failures++;
        $display("FAIL midreset_frame: word=%h cyc=%0d, required a5a5a5a5 %0d", got_wv_word[0],
                 got_wv_cyc[0], s + LAT);
      end
    end
  endtask

`ifdef PARITY_CHECK_EN
  task automatic test_parity();
    int s;
    clear_got();
    send_frame(32'h00000001, 1'b0, 1'b0, 4, s);
    checks++;
    if (got_wv_cyc.size() != 1 || got_pe_cyc.size() != 0 || word !== 32'h00000001) begin
      failures++;
      $display("FAIL parity_good: wv=%0d pe=%0d word=%h, required 1 0 00000001",
               got_wv_cyc.size(), got_pe_cyc.size(), word);
    end
    clear_got();
    send_frame(32'h00000001, 1'b0, 1'b1, 4, s);
    checks++;
    if (got_wv_cyc.size() != 0 || got_pe_cyc.size() != 1) begin
      failures++;
      $display("FAIL parity_bad: wv=%0d pe=%0d, required 0 1", got_wv_cyc.size(),
               got_pe_cyc.size());
    end
    checks++;
    if (word !== 32'h00000001) begin
      failures++;
      $display("FAIL parity_hold: word=%h, required 00000001", word);
    end
  endtask
`endif

  // Frame-level model: a frame yields a word only with stop 0 and good parity.
  task automatic test_random();
    int                exp_wv_cyc[$];
    logic [WORD_W-1:0] exp_wv_word[$];
    int                exp_fe_cyc[$];
    int                exp_pe_cyc[$];
    logic [WORD_W-1:0] model_word;
    logic [WORD_W-1:0] d;
    logic              stop;
    logic              flip;
    int                gap;
    int                s;
    model_word = word;
    clear_got();
    for (int n = 0; n < 20; n++) begin
      d    = $urandom;
      stop = ($urandom_range(3) == 0);
      flip = (PAR != 0) && ($urandom_range(3) == 0);
      gap  = stop ? 2 * BP + $urandom_range(4) : $urandom_range(5);
      send_frame(d, stop, flip, gap, s);
      if (stop) exp_fe_cyc.push_back(s + LAT);
      if (flip) exp_pe_cyc.push_back(s + LAT);
      if (!stop && !flip) begin
        exp_wv_cyc.push_back(s + LAT);
        exp_wv_word.push_back(d);
        model_word = d;
      end
      checks++;
      if (word !== model_word) begin
        failures++;
        $display("FAIL rand_word[%0d]: got %h, required %h", n, word, model_word);
      end
    end
    checks++;
    if (got_wv_cyc.size() != exp_wv_cyc.size()) begin
      failures++;
      $display("FAIL rand_wv_count: got %0d, required %0d", got_wv_cyc.size(), exp_wv_cyc.size());
    end else begin
      foreach (exp_wv_cyc[i]) begin
        checks++;
        if (got_wv_cyc[i] != exp_wv_cyc[i] || got_wv_word[i] !== exp_wv_word[i]) begin
          failures++;
          $display("FAIL rand_wv[%0d]: got %h@%0d, required %h@%0d", i, got_wv_word[i],
                   got_wv_cyc[i], exp_wv_word[i], exp_wv_cyc[i]);
        end
      end
    end
    checks++;
    if (got_fe_cyc != exp_fe_cyc) begin
      failures++;
      $display("FAIL rand_fe: got %0d pulses, required %0d", got_fe_cyc.size(), exp_fe_cyc.size());
    end
    checks++;
    if (got_pe_cyc != exp_pe_cyc) begin
      failures++;
      $display("FAIL rand_pe: got %0d pulses, required %0d", got_pe_cyc.size(), exp_pe_cyc.size());
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    rx_in    = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid();
`ifdef PARITY_CHECK_EN
    test_parity();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
